// File: rtl/pila_pkg.sv
// Shared defaults and sizing helpers for the pila LIFO stack.
package pila_pkg;

   localparam int unsigned DEF_WIDTH = 10;
   localparam int unsigned DEF_DEPTH = 8;

   // Bits needed to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned calc_cw(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address depth entries (at least one).
   function automatic int unsigned calc_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pila_sync_if.sv
// Command and status bundle between the PC logic (master) and the stack (slave).
interface pila_sync_if
   import pila_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) ();

   localparam int unsigned CW = calc_cw(DEPTH);

   logic             push;
   logic             pop;
   logic             clear;
   logic [WIDTH-1:0] inpush;
   logic [WIDTH-1:0] outpop;
   logic [WIDTH-1:0] top;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output push, pop, clear, inpush,
      input  outpop, top, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, clear, inpush,
      output outpop, top, count, empty, full, overflow, underflow
   );

endinterface

// File: rtl/pila_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module pila_mem
   import pila_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   localparam int unsigned AW   = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: commit wdata on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pila_sync.sv
// Synchronous LIFO for return addresses. count doubles as the stack pointer;
// the top entry lives at mem[count-1].
module pila_sync
   import pila_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input logic        clk,
   input logic        reset,
   pila_sync_if.slave bus
);

   localparam int unsigned CW = calc_cw(DEPTH);
   localparam int unsigned AW = calc_aw(DEPTH);

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] outpop_q, outpop_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             is_empty, is_full;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] rdata;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));

   // Top index is only formed when non-empty; slot 0 is a harmless default.
   assign raddr = is_empty ? '0 : AW'(count_q - CW'(1));

   pila_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (bus.inpush),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Next-state: clear beats push/pop; push+pop on non-empty replaces the top.
   always_comb begin
      count_d  = count_q;
      outpop_d = outpop_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      we       = 1'b0;
      waddr    = AW'(count_q);
      if (bus.clear) begin
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else begin
         unique case ({bus.push, bus.pop})
            2'b10: begin
               if (is_full) begin
                  ovf_d = 1'b1;
               end else begin
                  we      = 1'b1;
                  count_d = count_q + CW'(1);
               end
            end
            2'b01: begin
               if (is_empty) begin
                  unf_d = 1'b1;
               end else begin
                  outpop_d = rdata;
                  count_d  = count_q - CW'(1);
               end
            end
            2'b11: begin
               if (is_empty) begin
                  // Pop is dropped, push still lands in slot 0.
                  unf_d   = 1'b1;
                  we      = 1'b1;
                  waddr   = '0;
                  count_d = CW'(1);
               end else begin
                  outpop_d = rdata;
                  we       = 1'b1;
                  waddr    = raddr;
               end
            end
            default: ;
         endcase
      end
   end

   // State register: asynchronous reset clears count, flags and outpop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= '0;
         outpop_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         outpop_q <= outpop_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign bus.outpop    = outpop_q;
   assign bus.top       = is_empty ? '0 : rdata;
   assign bus.count     = count_q;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule

// File: tb/tb_pila_sync.sv
// Directed bench for pila_sync with WIDTH=10, DEPTH=8.
module tb_pila_sync;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   pila_sync_if #(.WIDTH(10), .DEPTH(8)) bus ();

   pila_sync #(
      .WIDTH (10),
      .DEPTH (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of commands, sample 1 time unit after the edge, then idle inputs.
   task automatic step(input logic p, input logic q, input logic c, input logic [9:0] d);
      bus.push   = p;
      bus.pop    = q;
      bus.clear  = c;
      bus.inpush = d;
      @(posedge clk);
      #1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
      bus.clear = 1'b0;
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      reset      = 1'b1;
      bus.push   = 1'b0;
      bus.pop    = 1'b0;
      bus.clear  = 1'b0;
      bus.inpush = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(bus.count), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      check("rst_unf", 32'(bus.underflow), 0);
      check("rst_outpop", 32'(bus.outpop), 0);
      check("rst_top", 32'(bus.top), 0);
      reset = 1'b0;

      // Basic push/pop ordering.
      step(1, 0, 0, 10'h001);
      step(1, 0, 0, 10'h002);
      step(1, 0, 0, 10'h003);
      check("p3_count", 32'(bus.count), 3);
      check("p3_top", 32'(bus.top), 10'h003);
      step(0, 1, 0, '0);
      check("pop1", 32'(bus.outpop), 10'h003);
      step(0, 1, 0, '0);
      check("pop2", 32'(bus.outpop), 10'h002);
      step(0, 1, 0, '0);
      check("pop3", 32'(bus.outpop), 10'h001);
      check("pop3_empty", 32'(bus.empty), 1);
      check("pop3_top", 32'(bus.top), 0);

      // Fill to full, then overflow.
      for (int i = 0; i < 8; i++) step(1, 0, 0, 10'(32'h100 + i));
      check("fill_full", 32'(bus.full), 1);
      check("fill_count", 32'(bus.count), 8);
      check("fill_top", 32'(bus.top), 10'h107);
      step(1, 0, 0, 10'h3FF);
      check("ovf_count", 32'(bus.count), 8);
      check("ovf_flag", 32'(bus.overflow), 1);
      check("ovf_top", 32'(bus.top), 10'h107);
      step(0, 1, 0, '0);
      check("ovf_pop", 32'(bus.outpop), 10'h107);
      check("ovf_pop_cnt", 32'(bus.count), 7);
      check("ovf_sticky", 32'(bus.overflow), 1);

      // Clear, then underflow on empty.
      step(0, 0, 1, '0);
      check("clr_count", 32'(bus.count), 0);
      check("clr_ovf", 32'(bus.overflow), 0);
      check("clr_outpop", 32'(bus.outpop), 10'h107);
      step(0, 1, 0, '0);
      check("unf_flag", 32'(bus.underflow), 1);
      check("unf_outpop", 32'(bus.outpop), 10'h107);
      check("unf_count", 32'(bus.count), 0);
      step(0, 0, 1, '0);
      check("unf_clr", 32'(bus.underflow), 0);

      // Replace-top at count=2 and at full.
      step(1, 0, 0, 10'h033);
      step(1, 0, 0, 10'h055);
      check("rt_top0", 32'(bus.top), 10'h055);
      step(1, 1, 0, 10'h0AA);
      check("rt_outpop", 32'(bus.outpop), 10'h055);
      check("rt_top", 32'(bus.top), 10'h0AA);
      check("rt_count", 32'(bus.count), 2);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 10'(32'h200 + i));
      check("rtf_full", 32'(bus.full), 1);
      step(1, 1, 0, 10'h2AA);
      check("rtf_outpop", 32'(bus.outpop), 10'h205);
      check("rtf_top", 32'(bus.top), 10'h2AA);
      check("rtf_count", 32'(bus.count), 8);
      check("rtf_ovf", 32'(bus.overflow), 0);
      step(0, 1, 0, '0);
      check("rtf_pop", 32'(bus.outpop), 10'h2AA);
      step(0, 1, 0, '0);
      check("rtf_pop2", 32'(bus.outpop), 10'h204);

      // Push+pop on empty: push lands, underflow set.
      step(0, 0, 1, '0);
      step(1, 1, 0, 10'h123);
      check("pe_count", 32'(bus.count), 1);
      check("pe_top", 32'(bus.top), 10'h123);
      check("pe_unf", 32'(bus.underflow), 1);
      check("pe_outpop", 32'(bus.outpop), 10'h204);

      // Asynchronous reset mid-cycle with a push pending.
      step(0, 0, 1, '0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 10'(32'h300 + i));
      check("ar_pre", 32'(bus.count), 5);
      bus.push   = 1'b1;
      bus.inpush = 10'h3EE;
      #2;
      reset = 1'b1;
      #1;
      check("ar_count", 32'(bus.count), 0);
      check("ar_empty", 32'(bus.empty), 1);
      check("ar_outpop", 32'(bus.outpop), 0);
      check("ar_unf", 32'(bus.underflow), 0);
      @(posedge clk);
      #1;
      check("ar_hold", 32'(bus.count), 0);
      bus.push = 1'b0;
      reset    = 1'b0;
      step(1, 0, 0, 10'h010);
      check("ar_post_cnt", 32'(bus.count), 1);
      check("ar_post_top", 32'(bus.top), 10'h010);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
